// File: rtl/instr_mem_responder_if.sv
// Fetch interface between the PC unit and the instruction memory.
// The PC unit drives requests; the memory side answers one cycle later.
interface instr_mem_responder_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        instr_fault;

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, instr_valid, instr_out, instr_fault
  );

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, instr_valid, instr_out, instr_fault
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory answering PC fetches with 1-cycle latency.
// A byte-serial loader fills the array from a boot/debug source.
module instr_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                           clk,
  input  logic                           reset,
  instr_mem_responder_if.slave           fetch,
  input  logic                           load_start,
  input  logic                           load_byte_valid,
  input  logic [7:0]                     load_byte,
  input  logic                           load_end,
  output logic                           load_busy,
  output logic                           load_done,
  output logic [$clog2(DEPTH_WORDS):0]   loaded_words
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    byte_idx;
  logic [CW-1:0] word_idx;
  logic [31:0]   asm_word;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          take;
  logic          full;
  logic          flush;
  logic          wr_en;
  logic [31:0]   merged;
  logic          accept;
  logic [29:0]   idx;
  logic          fault;

  // Lanes above byte_idx in asm_word are always zero, so OR-ing the
  // incoming byte yields both the full word and the zero-padded tail.
  assign take   = (state == LOAD) && load_byte_valid;
  assign full   = take && (byte_idx == 2'd3);
  assign flush  = (state == LOAD) && load_end
                  && (take || (byte_idx != 2'd0));
  assign wr_en  = full || flush;
  assign merged = asm_word
                  | (take ? ({24'b0, load_byte} << {byte_idx, 3'b000})
                          : 32'b0);

  assign accept = fetch.fetch_req && fetch.fetch_ready;
  assign idx    = fetch.fetch_addr[31:2];
  assign fault  = (fetch.fetch_addr[1:0] != 2'b00)
                  || (idx >= 30'(loaded_words));

  assign fetch.fetch_ready = (state == IDLE);
  assign load_busy         = (state != IDLE);
  assign load_done         = (state == DONE);

  // Loader state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Loader next-state: leave LOAD on load_end or once the array is full.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load_start) state_nx = LOAD;
      LOAD: begin
        if (load_end || (wr_en && (word_idx == LAST)))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte assembly and word/valid-count bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx     <= '0;
      word_idx     <= '0;
      asm_word     <= '0;
      loaded_words <= '0;
    end else if ((state == IDLE) && load_start) begin
      byte_idx     <= '0;
      word_idx     <= '0;
      asm_word     <= '0;
      loaded_words <= '0;
    end else if (wr_en) begin
      byte_idx     <= '0;
      asm_word     <= '0;
      word_idx     <= word_idx + 1'b1;
      loaded_words <= word_idx + 1'b1;
    end else if (take) begin
      asm_word[{byte_idx, 3'b000} +: 8] <= load_byte;
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[word_idx[AW-1:0]] <= merged;
  end

  // Registered fetch response; word and fault hold between accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch.instr_valid <= 1'b0;
      fetch.instr_out   <= NOP_WORD;
      fetch.instr_fault <= 1'b0;
    end else begin
      fetch.instr_valid <= accept;
      if (accept) begin
        fetch.instr_fault <= fault;
        fetch.instr_out   <= fault ? NOP_WORD : mem[idx[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: default depth plus a
// 4-word instance for the auto-finish and reset-abort cases.
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        load_start;
  logic        lbv;
  logic [7:0]  lbyte;
  logic        load_end;

  logic        lb0, ld0, lb1, ld1;
  logic [8:0]  lw0;
  logic [2:0]  lw1;

  int vectors;
  int miscompares;

  instr_mem_responder_if f0 ();
  instr_mem_responder_if f1 ();

  assign f0.fetch_req  = fetch_req;
  assign f0.fetch_addr = fetch_addr;
  assign f1.fetch_req  = fetch_req;
  assign f1.fetch_addr = fetch_addr;

  instr_mem_responder u0 (
    .clk             (clk),
    .reset           (reset),
    .fetch           (f0),
    .load_start      (load_start),
    .load_byte_valid (lbv),
    .load_byte       (lbyte),
    .load_end        (load_end),
    .load_busy       (lb0),
    .load_done       (ld0),
    .loaded_words    (lw0)
  );

  instr_mem_responder #(.DEPTH_WORDS(4)) u1 (
    .clk             (clk),
    .reset           (reset),
    .fetch           (f1),
    .load_start      (load_start),
    .load_byte_valid (lbv),
    .load_byte       (lbyte),
    .load_end        (load_end),
    .load_busy       (lb1),
    .load_done       (ld1),
    .loaded_words    (lw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch0(input string tag,
                        input logic [31:0] a,
                        input logic ef,
                        input logic [31:0] ew);
    check({tag, "_rdy"}, 32'(f0.fetch_ready), 32'd1);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    check({tag, "_vld"}, 32'(f0.instr_valid), 32'd1);
    check({tag, "_flt"}, 32'(f0.instr_fault), 32'(ef));
    check({tag, "_ins"}, f0.instr_out, ew);
  endtask

  task automatic send(input logic [7:0] b);
    lbv   = 1'b1;
    lbyte = b;
    step();
    lbv = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [8];
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    fetch_req   = 1'b0;
    fetch_addr  = '0;
    load_start  = 1'b0;
    lbv         = 1'b0;
    lbyte       = '0;
    load_end    = 1'b0;
    prog = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};

    step();
    step();
    check("rst_vld", 32'(f0.instr_valid), 32'd0);
    check("rst_ins", f0.instr_out, NOP);
    check("rst_flt", 32'(f0.instr_fault), 32'd0);
    check("rst_lw", 32'(lw0), 32'd0);
    check("rst_rdy", 32'(f0.fetch_ready), 32'd1);
    check("rst_busy", 32'(lb0), 32'd0);
    check("rst_done", 32'(ld0), 32'd0);
    reset = 1'b1;
    step();

    fetch0("empty", 32'h0, 1'b1, NOP);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("ld_busy", 32'(lb0), 32'd1);
    check("ld_rdy", 32'(f0.fetch_ready), 32'd0);
    for (int i = 0; i < 8; i++) send(prog[i]);
    check("ld_lw_mid", 32'(lw0), 32'd2);
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    check("ld_done", 32'(ld0), 32'd1);
    check("ld_lw", 32'(lw0), 32'd2);
    check("ld_rdy_done", 32'(f0.fetch_ready), 32'd0);
    step();
    check("ld_done_clr", 32'(ld0), 32'd0);
    check("ld_busy_clr", 32'(lb0), 32'd0);

    fetch0("w0", 32'h0, 1'b0, 32'h00100093);
    fetch0("w1", 32'h4, 1'b0, 32'h00200113);

    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    step();
    check("b2b0_vld", 32'(f0.instr_valid), 32'd1);
    check("b2b0_ins", f0.instr_out, 32'h00100093);
    fetch_addr = 32'h4;
    step();
    check("b2b1_vld", 32'(f0.instr_valid), 32'd1);
    check("b2b1_ins", f0.instr_out, 32'h00200113);
    fetch_addr = 32'h8;
    step();
    check("b2b2_vld", 32'(f0.instr_valid), 32'd1);
    check("b2b2_flt", 32'(f0.instr_fault), 32'd1);
    check("b2b2_ins", f0.instr_out, NOP);
    fetch_req = 1'b0;
    step();
    check("hold_vld", 32'(f0.instr_valid), 32'd0);
    check("hold_flt", 32'(f0.instr_fault), 32'd1);
    check("hold_ins", f0.instr_out, NOP);

    fetch0("misal", 32'h2, 1'b1, NOP);
    fetch0("w0again", 32'h0, 1'b0, 32'h00100093);
    fetch0("hiaddr", 32'h8000_0000, 1'b1, NOP);

    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    step();
    load_start = 1'b0;
    check("ovl_vld", 32'(f0.instr_valid), 32'd1);
    check("ovl_ins", f0.instr_out, 32'h00200113);
    check("ovl_rdy", 32'(f0.fetch_ready), 32'd0);
    check("ovl_lw", 32'(lw0), 32'd0);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    check("ovl_stall", 32'(f0.instr_valid), 32'd0);
    load_end = 1'b1;
    send(8'hEE);
    load_end = 1'b0;
    check("part_done", 32'(ld0), 32'd1);
    check("part_lw", 32'(lw0), 32'd2);
    check("part_rdy", 32'(f0.fetch_ready), 32'd0);
    step();
    check("part_idle_vld", 32'(f0.instr_valid), 32'd0);
    step();
    fetch_req = 1'b0;
    check("held_vld", 32'(f0.instr_valid), 32'd1);
    check("held_ins", f0.instr_out, 32'h000000EE);
    fetch0("part_w0", 32'h0, 1'b0, 32'hDDCCBBAA);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(8'(i + 1));
      if (i == 15) begin
        check("auto_done", 32'(ld1), 32'd1);
        check("auto_lw", 32'(lw1), 32'd4);
      end
    end
    check("auto_lw_end", 32'(lw1), 32'd4);
    check("auto_busy", 32'(lb1), 32'd0);
    fetch_req  = 1'b1;
    fetch_addr = 32'hC;
    step();
    fetch_req = 1'b0;
    check("d4_w3_vld", 32'(f1.instr_valid), 32'd1);
    check("d4_w3_ins", f1.instr_out, 32'h100F0E0D);
    check("d4_w3_flt", 32'(f1.instr_fault), 32'd0);
    fetch_req  = 1'b1;
    fetch_addr = 32'h10;
    step();
    fetch_req = 1'b0;
    check("d4_oob_flt", 32'(f1.instr_fault), 32'd1);
    check("d4_oob_ins", f1.instr_out, NOP);

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("abort_busy", 32'(lb1), 32'd1);
    send(8'h55);
    send(8'h66);
    reset = 1'b0;
    #1;
    check("abort_lw1", 32'(lw1), 32'd0);
    check("abort_lw0", 32'(lw0), 32'd0);
    check("abort_busy0", 32'(lb1), 32'd0);
    step();
    reset = 1'b1;
    step();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    check("abort_vld", 32'(f1.instr_valid), 32'd1);
    check("abort_flt", 32'(f1.instr_fault), 32'd1);
    check("abort_ins", f1.instr_out, NOP);
    check("abort_flt0", 32'(f0.instr_fault), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
